acl_sequencer: RTL and testbench
================================

Name: acl_sequencer

Overview:
- Command sequencer that owns the PMOD ACL2 SPI transaction engine's command port (load, instr, addr, wdata, rdata).
- After reset it initialises the ADXL362: soft reset, settle, then measurement mode.
- It then runs periodic 8-bit X/Y/Z burst reads and publishes each coherent sample set with a valid pulse.
- Sits between the SPI engine and the user logic that consumes acceleration samples.

Parameters:
- SETTLE_CYC, 1000, clk cycles waited after soft-reset write before POWER_CTL write (minimum 1).
- SAMPLE_DIV, 100000, clk cycles from one sample-set start to the next (minimum 16).
- TIMEOUT_CYC, 4096, clk cycles allowed between spi_load and spi_done before declaring an error.

Ports:
- clk  in  1  system clock; same clock as the SPI engine.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  level; 1 allows periodic sampling once init is complete.
- spi_load  out  1  one-cycle command strobe to the SPI engine.
- spi_instr  out  8  instruction byte: 0x0A = write, 0x0B = read.
- spi_addr  out  8  register address.
- spi_wdata  out  8  write data; 0x00 on reads.
- spi_done  in  1  one-cycle pulse from the engine when a transaction has ended.
- spi_rdata  in  8  read data; valid in the cycle spi_done is high.
- x_data  out  8  last published X sample.
- y_data  out  8  last published Y sample.
- z_data  out  8  last published Z sample.
- sample_valid  out  1  one-cycle pulse when x/y/z_data update.
- init_done  out  1  high once initialisation has completed.
- err  out  1  sticky; set on timeout, cleared only by rst.

Behaviour:
- Reset: all outputs 0, and spi_instr/addr/wdata = 0x00. State = S_SRST. Internal shadow registers = 0. Reset may be asserted at any time, including mid-transaction; the sequencer restarts from S_SRST on release and drives no further load.
- Transaction rule:
  - spi_load is high for exactly one cycle, with instr/addr/wdata valid in that cycle and held stable until spi_done.
  - The sequencer never issues a new load before spi_done for the previous command.
  - A timeout counter starts at load. If spi_done has not arrived after TIMEOUT_CYC cycles: err=1, state -> S_ERR.
  - spi_done arriving while no command is outstanding is ignored.
- States:
  - S_SRST: issue write 0x1F=0x52; on done -> S_SETTLE.
  - S_SETTLE: count SETTLE_CYC cycles -> S_PWR.
  - S_PWR: issue write 0x2D=0x02; on done, init_done=1 -> S_IDLE.
  - S_IDLE: a sample tick fires every SAMPLE_DIV cycles (free-running divider, starts at init_done). On a tick with enable=1 -> S_RDX.
    - A tick with enable=0 is dropped.
    - A tick arriving while a set is still in flight is dropped; no queuing. Count dropped ticks only if a debug counter is added later (not required).
  - S_RDX: read 0x08; on done, capture spi_rdata into shadow X -> S_RDY.
  - S_RDY: read 0x09; on done, capture into shadow Y -> S_RDZ.
  - S_RDZ: read 0x0A; on done, capture into shadow Z -> S_PUB.
  - S_PUB: copy shadows to x/y/z_data, pulse sample_valid for 1 cycle -> S_IDLE.
  - S_ERR: terminal; spi_load held 0; outputs retain their last values.
- Deasserting enable mid-set: the current set completes and is published; no further sets start.
- Published outputs change only in S_PUB, so x/y/z always come from the same set.
- Latency: sample_valid is asserted 1 cycle after the final spi_done of the set.

Optional Feature:
- Macro ACL_TEMP_EN.
- Defined:
  - Adds port temp_data out 8.
  - Adds state S_RDT between S_RDZ and S_PUB: read 0x14 into shadow T.
  - temp_data updates together with x/y/z in S_PUB; reset value 0.
- Undefined: no temp_data port and no S_RDT; S_RDZ goes directly to S_PUB.

Test Plan:
- Reset release, engine model answers spi_done 20 cycles after each load -> two writes observed in order: (0x0A,0x1F,0x52), then after ≥SETTLE_CYC idle cycles (0x0A,0x2D,0x02); init_done rises 1 cycle after the second done.
- enable=1, model returns 0x11/0x22/0x33 for addresses 0x08/0x09/0x0A -> reads issued in order 0x08, 0x09, 0x0A; a single sample_valid pulse; x/y/z = 0x11/0x22/0x33; outputs unchanged between pulses.
- Next set: model returns 0x44 for X, then stalls Y for TIMEOUT_CYC+1 cycles -> err=1 at the timeout; no sample_valid; x_data still 0x11; no further loads.
- enable dropped after the X-read load -> Y and Z reads still complete and are published; no load on subsequent ticks; re-enabling resumes sampling on the next tick.
- rst pulsed during the Y read -> outputs go to 0 immediately (asynchronous); after release the sequence restarts with the 0x1F write.
- With ACL_TEMP_EN, model returns 0x5A at address 0x14 -> a fourth read of 0x14 follows 0x0A; temp_data=0x5A in the same cycle as sample_valid.

Source files
------------

// File: rtl/acl_sequencer.sv
// acl_sequencer: ADXL362 init (soft reset, settle, measure mode) then periodic X/Y/Z reads via the SPI engine.
// Define ACL_TEMP_EN to add a temperature read (0x14) and the temp_data port.
module acl_sequencer #(
    parameter int SETTLE_CYC  = 1000,
    parameter int SAMPLE_DIV  = 100000,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic       spi_load,
    output logic [7:0] spi_instr,
    output logic [7:0] spi_addr,
    output logic [7:0] spi_wdata,
    input  logic       spi_done,
    input  logic [7:0] spi_rdata,
    output logic [7:0] x_data,
    output logic [7:0] y_data,
    output logic [7:0] z_data,
`ifdef ACL_TEMP_EN
    output logic [7:0] temp_data,
`endif
    output logic       sample_valid,
    output logic       init_done,
    output logic       err
);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int DW = $clog2(SAMPLE_DIV);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {
        S_SRST, S_SETTLE, S_PWR, S_IDLE, S_RDX, S_RDY, S_RDZ,
`ifdef ACL_TEMP_EN
        S_RDT,
`endif
        S_PUB, S_ERR
    } state_t;

    state_t        state;
    logic          pending;
    logic [SW-1:0] settle_cnt;
    logic [DW-1:0] div_cnt;
    logic [TW-1:0] tmo;
    logic [7:0]    sh_x, sh_y;
`ifdef ACL_TEMP_EN
    logic [7:0]    sh_z;
`endif
    logic          is_cmd, tick;
    logic [7:0]    cmd_instr, cmd_addr, cmd_wdata;

    assign tick = init_done && div_cnt == DW'(SAMPLE_DIV - 1);

    always_comb begin
        is_cmd    = 1'b1;
        cmd_instr = 8'h0B;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        case (state)
            S_SRST: begin cmd_instr = 8'h0A; cmd_addr = 8'h1F; cmd_wdata = 8'h52; end
            S_PWR:  begin cmd_instr = 8'h0A; cmd_addr = 8'h2D; cmd_wdata = 8'h02; end
            S_RDX:  cmd_addr = 8'h08;
            S_RDY:  cmd_addr = 8'h09;
            S_RDZ:  cmd_addr = 8'h0A;
`ifdef ACL_TEMP_EN
            S_RDT:  cmd_addr = 8'h14;
`endif
            default: is_cmd = 1'b0;
        endcase
    end

    // The last read of a set publishes directly so sample_valid lands one cycle after its done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_SRST;
            pending      <= 1'b0;
            settle_cnt   <= '0;
            div_cnt      <= '0;
            tmo          <= '0;
            sh_x         <= 8'h00;
            sh_y         <= 8'h00;
`ifdef ACL_TEMP_EN
            sh_z         <= 8'h00;
            temp_data    <= 8'h00;
`endif
            spi_load     <= 1'b0;
            spi_instr    <= 8'h00;
            spi_addr     <= 8'h00;
            spi_wdata    <= 8'h00;
            x_data       <= 8'h00;
            y_data       <= 8'h00;
            z_data       <= 8'h00;
            sample_valid <= 1'b0;
            init_done    <= 1'b0;
            err          <= 1'b0;
        end else begin
            spi_load     <= 1'b0;
            sample_valid <= 1'b0;
            div_cnt      <= (!init_done || tick) ? '0 : div_cnt + 1'b1;
            if (is_cmd && !pending) begin
                spi_load  <= 1'b1;
                spi_instr <= cmd_instr;
                spi_addr  <= cmd_addr;
                spi_wdata <= cmd_wdata;
                pending   <= 1'b1;
                tmo       <= '0;
            end else if (is_cmd) begin
                if (spi_done) begin
                    pending <= 1'b0;
                    case (state)
                        S_SRST: state <= S_SETTLE;
                        S_PWR: begin init_done <= 1'b1; state <= S_IDLE; end
                        S_RDX: begin sh_x <= spi_rdata; state <= S_RDY; end
                        S_RDY: begin sh_y <= spi_rdata; state <= S_RDZ; end
`ifdef ACL_TEMP_EN
                        S_RDZ: begin sh_z <= spi_rdata; state <= S_RDT; end
                        S_RDT: begin
                            x_data       <= sh_x;
                            y_data       <= sh_y;
                            z_data       <= sh_z;
                            temp_data    <= spi_rdata;
                            sample_valid <= 1'b1;
                            state        <= S_PUB;
                        end
`else
                        S_RDZ: begin
                            x_data       <= sh_x;
                            y_data       <= sh_y;
                            z_data       <= spi_rdata;
                            sample_valid <= 1'b1;
                            state        <= S_PUB;
                        end
`endif
                        default: state <= S_ERR;
                    endcase
                end else if (tmo == TW'(TIMEOUT_CYC - 1)) begin
                    pending <= 1'b0;
                    err     <= 1'b1;
                    state   <= S_ERR;
                end else begin
                    tmo <= tmo + 1'b1;
                end
            end else begin
                case (state)
                    S_SETTLE: begin
                        settle_cnt <= (settle_cnt == SW'(SETTLE_CYC - 1)) ? '0 : settle_cnt + 1'b1;
                        state      <= (settle_cnt == SW'(SETTLE_CYC - 1)) ? S_PWR : S_SETTLE;
                    end
                    S_IDLE:  state <= (tick && enable) ? S_RDX : S_IDLE;
                    S_PUB:   state <= S_IDLE;
                    default: state <= state;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_acl_sequencer.sv
// tb_acl_sequencer: scoreboard bench; an engine model answers loads, a monitor checks loads and samples in order.
module tb_acl_sequencer;
    localparam int SETTLE = 10;
    localparam int DIV    = 200;
    localparam int TMO    = 64;
    localparam int LAT    = 20;

    logic       clk = 1'b0, rst = 1'b1, enable = 1'b0;
    logic       spi_load, spi_done = 1'b0;
    logic [7:0] spi_instr, spi_addr, spi_wdata, spi_rdata = 8'h00;
    logic [7:0] x_data, y_data, z_data, t_out;
    logic       sample_valid, init_done, err;
`ifdef ACL_TEMP_EN
    logic [7:0] temp_data;
    assign t_out = temp_data;
`else
    assign t_out = 8'h00;
`endif

    int errors = 0, checks = 0, cyc = 0, n_loads = 0, n_smp = 0;
    int load_cyc = 0, done_cyc = 0;
    logic [7:0] rx = 8'h11, ry = 8'h22, rz = 8'h33;
    logic       stall_y = 1'b0;
    logic [23:0] exp_cmd[$];
    logic [31:0] exp_smp[$];

    acl_sequencer #(.SETTLE_CYC(SETTLE), .SAMPLE_DIV(DIV), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .spi_load(spi_load), .spi_instr(spi_instr), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
        .spi_done(spi_done), .spi_rdata(spi_rdata),
        .x_data(x_data), .y_data(y_data), .z_data(z_data),
`ifdef ACL_TEMP_EN
        .temp_data(temp_data),
`endif
        .sample_valid(sample_valid), .init_done(init_done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rd(logic [7:0] a);
        case (a)
            8'h08:   return rx;
            8'h09:   return ry;
            8'h0A:   return rz;
            8'h14:   return 8'h5A;
            default: return 8'h00;
        endcase
    endfunction

    task automatic push_init();
        exp_cmd.push_back(24'h0A1F52);
        exp_cmd.push_back(24'h0A2D02);
    endtask

    task automatic push_set(logic [7:0] x, logic [7:0] y, logic [7:0] z);
        exp_cmd.push_back(24'h0B0800);
        exp_cmd.push_back(24'h0B0900);
        exp_cmd.push_back(24'h0B0A00);
`ifdef ACL_TEMP_EN
        exp_cmd.push_back(24'h0B1400);
        exp_smp.push_back({x, y, z, 8'h5A});
`else
        exp_smp.push_back({x, y, z, 8'h00});
`endif
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_loads(int n, int budget);
        for (int i = 0; i < budget && n_loads < n; i++) step();
        chk("wait_loads", 32'(n_loads >= n), 1);
    endtask

    task automatic wait_smp(int n, int budget);
        for (int i = 0; i < budget && n_smp < n; i++) step();
        chk("wait_sample", 32'(n_smp >= n), 1);
    endtask

    task automatic wait_sig(string name, ref logic s, input int budget);
        for (int i = 0; i < budget && s !== 1'b1; i++) step();
        chk(name, 32'(s), 1);
    endtask

    // Engine model: answers each load LAT cycles later unless stalled or reset intervenes.
    initial begin : engine
        logic [7:0] a;
        forever begin
            @(negedge clk);
            if (spi_load && !rst && !(stall_y && spi_addr == 8'h09)) begin
                a = spi_addr;
                for (int i = 1; i < LAT && !rst; i++) @(negedge clk);
                if (!rst) begin
                    spi_done  = 1'b1;
                    spi_rdata = rd(a);
                    done_cyc  = cyc;
                    @(negedge clk);
                    spi_done  = 1'b0;
                    spi_rdata = 8'h00;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (spi_load) begin
            n_loads++;
            load_cyc = cyc;
            if (exp_cmd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_load: got %h%h%h expected none", spi_instr, spi_addr, spi_wdata);
            end else chk("load_cmd", {8'h00, spi_instr, spi_addr, spi_wdata}, {8'h00, exp_cmd.pop_front()});
        end
        if (sample_valid) begin
            n_smp++;
            if (exp_smp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sample: got %h%h%h expected none", x_data, y_data, z_data);
            end else chk("sample", {x_data, y_data, z_data, t_out}, exp_smp.pop_front());
        end
    end

    initial begin
        int nl, ns, yc;
        logic changed;
        logic [23:0] snap;
        repeat (3) step();
        chk("reset_ctrl", {19'h0, spi_load, sample_valid, init_done, err, spi_instr | spi_addr | spi_wdata}, 0);
        chk("reset_data", {x_data, y_data, z_data, t_out}, 0);
        push_init();
        @(negedge clk);
        rst = 1'b0;
        wait_loads(2, 400);
        chk("settle_gap", 32'(load_cyc - done_cyc >= SETTLE), 1);
        wait_sig("init_done", init_done, 100);
        chk("init_latency", cyc - done_cyc, 1);

        push_set(8'h11, 8'h22, 8'h33);
        enable = 1'b1;
        wait_smp(1, 2 * DIV);
        snap = {x_data, y_data, z_data};
        changed = 1'b0;
        repeat (60) begin
            step();
            if ({x_data, y_data, z_data} !== snap) changed = 1'b1;
        end
        chk("hold_between", 32'(changed), 0);

        rx = 8'h55; ry = 8'h66; rz = 8'h77;
        push_set(8'h55, 8'h66, 8'h77);
        nl = n_loads;
        wait_loads(nl + 1, DIV + 10);
        enable = 1'b0;
        wait_smp(2, 200);
        nl = n_loads;
        repeat (2 * DIV + 10) step();
        chk("no_load_disabled", n_loads, nl);
        chk("x_after_drop", 32'(x_data), 32'h55);

        rx = 8'h12; ry = 8'h34; rz = 8'h56;
        push_set(8'h12, 8'h34, 8'h56);
        enable = 1'b1;
        wait_loads(nl + 1, DIV + 5);
        wait_smp(3, 200);

        rx = 8'h11; ry = 8'h22; rz = 8'h33;
        exp_cmd.push_back(24'h0B0800);
        exp_cmd.push_back(24'h0B0900);
        nl = n_loads;
        wait_loads(nl + 2, 2 * DIV);
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_data", {x_data, y_data, z_data, t_out}, 0);
        chk("async_rst_ctrl", {28'h0, spi_load, sample_valid, init_done, err}, 0);
        repeat (3) step();
        push_init();
        rst = 1'b0;
        wait_sig("reinit_done", init_done, 400);
        ns = n_smp;
        push_set(8'h11, 8'h22, 8'h33);
        wait_smp(ns + 1, 2 * DIV);

        rx = 8'h44;
        stall_y = 1'b1;
        exp_cmd.push_back(24'h0B0800);
        exp_cmd.push_back(24'h0B0900);
        nl = n_loads;
        wait_loads(nl + 2, 2 * DIV);
        yc = load_cyc;
        wait_sig("err_set", err, TMO + 20);
        chk("timeout_latency", 32'(cyc - yc >= TMO && cyc - yc <= TMO + 1), 1);
        chk("x_kept", 32'(x_data), 32'h11);
        ns = n_smp;
        nl = n_loads;
        repeat (3 * DIV) step();
        chk("no_load_after_err", n_loads, nl);
        chk("no_sample_after_err", n_smp, ns);
        chk("err_sticky", 32'(err), 1);
        chk("cmd_queue_empty", exp_cmd.size(), 0);
        chk("smp_queue_empty", exp_smp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
